// File: rtl/cache_axi_bridge_pkg.sv
// rtl/cache_axi_bridge_pkg.sv - shared types, constants and helpers for the cache AXI bridge
package cache_axi_bridge_pkg;

  // cache access type codes (rd_type / wr_type)
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // AXI constants
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  localparam int         LINE_WORDS_DEF = 4;
  localparam logic [3:0] RD_ID_DEF      = 4'd0;
  localparam logic [3:0] WR_ID_DEF      = 4'd1;

  // one-hot FSM encodings
  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_AR   = 3'b010,
    R_DATA = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_DATA = 3'b010,
    W_B    = 3'b100
  } wr_state_e;

  // line accesses move whole words; uncached ones use the natural size
  function automatic logic [2:0] axi_size(input logic [2:0] t);
    return (t == TYPE_LINE) ? SIZE_WORD : {1'b0, t[1:0]};
  endfunction

  function automatic logic [7:0] axi_len(input logic [2:0] t, input int words);
    return (t == TYPE_LINE) ? 8'(words - 1) : 8'd0;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_wr_beat.sv
// rtl/cache_axi_bridge_wr_beat.sv - write beat counter, data mux, wlast and AW/W completion flags
module axi_wr_beat_ctrl (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         active_i,
  input  logic         clear_i,
  input  logic         awready_i,
  input  logic         wready_i,
  input  logic [1:0]   last_beat_i,
  input  logic [127:0] data_i,
  output logic         awvalid_o,
  output logic         wvalid_o,
  output logic [31:0]  wdata_o,
  output logic         wlast_o,
  output logic         aw_done_o,
  output logic         w_done_o
);

  logic [1:0] beat_q, beat_d;
  logic       aw_done_q, w_done_q;

  assign awvalid_o = active_i && !aw_done_q;
  assign wvalid_o  = active_i && !w_done_q;
  assign wlast_o   = (beat_q == last_beat_i);
  assign wdata_o   = data_i[{beat_q, 5'd0} +: 32];
  assign aw_done_o = aw_done_q;
  assign w_done_o  = w_done_q;

  // next beat: advance on each accepted non-final beat, reset when the B response retires the burst
  always_comb begin
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = 2'd0;
    end else if (wvalid_o && wready_i && !wlast_o) begin
      beat_d = beat_q + 2'd1;
    end
  end

  // beat counter and sticky handshake-complete flags; AW and W may finish in any order
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      beat_q    <= 2'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      if (clear_i) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (awvalid_o && awready_i) aw_done_q <= 1'b1;
        if (wvalid_o && wready_i && wlast_o) w_done_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache refill/writeback port to AXI4 master bridge
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int         LINE_WORDS = LINE_WORDS_DEF,
  parameter logic [3:0] RD_ID      = RD_ID_DEF,
  parameter logic [3:0] WR_ID      = WR_ID_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_e    r_state_q;
  wr_state_e    w_state_q;
  logic [31:0]  araddr_q;
  logic [7:0]   arlen_q;
  logic [2:0]   arsize_q;
  logic [31:0]  wr_addr_q;
  logic [2:0]   wr_type_q;
  logic [3:0]   wr_strb_q;
  logic [127:0] wr_data_q;
  logic [7:0]   awlen_q;
  logic [2:0]   awsize_q;
  logic         aw_done, w_done;
  logic         raw_block;
  logic         unused_resp;

  // responses are not checked; IDs are constant per direction
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // a read may not overtake a pending write to the same cache line
  assign raw_block = (w_state_q != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4]);

  assign rd_rdy    = (r_state_q == R_IDLE) && !raw_block;
  assign arid      = RD_ID;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = BURST_INCR;
  assign arvalid   = (r_state_q == R_AR);
  assign rready    = (r_state_q == R_DATA);
  assign ret_valid = (r_state_q == R_DATA) && rvalid;
  assign ret_last  = (r_state_q == R_DATA) && rvalid && rlast;
  assign ret_data  = rdata;

  // read FSM: latch request, issue AR, then stream R beats straight back to the cache
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
    end else begin
      case (r_state_q)
        R_IDLE: if (rd_req && rd_rdy) begin
          araddr_q  <= rd_addr;
          arlen_q   <= axi_len(rd_type, LINE_WORDS);
          arsize_q  <= axi_size(rd_type);
          r_state_q <= R_AR;
        end
        R_AR:    if (arready) r_state_q <= R_DATA;
        R_DATA:  if (rvalid && rlast) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign wr_rdy  = (w_state_q == W_IDLE);
  assign awid    = WR_ID;
  assign awaddr  = wr_addr_q;
  assign awlen   = awlen_q;
  assign awsize  = awsize_q;
  assign awburst = BURST_INCR;
  assign wstrb   = (wr_type_q == TYPE_LINE) ? 4'hf : wr_strb_q;
  assign bready  = (w_state_q == W_B);

  // write FSM: latch request, run AW/W concurrently, then wait for B
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      wr_addr_q <= 32'd0;
      wr_type_q <= 3'd0;
      wr_strb_q <= 4'd0;
      wr_data_q <= 128'd0;
      awlen_q   <= 8'd0;
      awsize_q  <= 3'd0;
    end else begin
      case (w_state_q)
        W_IDLE: if (wr_req) begin
          wr_addr_q <= wr_addr;
          wr_type_q <= wr_type;
          wr_strb_q <= wr_wstrb;
          wr_data_q <= wr_data;
          awlen_q   <= axi_len(wr_type, LINE_WORDS);
          awsize_q  <= axi_size(wr_type);
          w_state_q <= W_DATA;
        end
        W_DATA:  if (aw_done && w_done) w_state_q <= W_B;
        W_B:     if (bvalid) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  axi_wr_beat_ctrl u_wr_beat (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .active_i    (w_state_q == W_DATA),
    .clear_i     ((w_state_q == W_B) && bvalid),
    .awready_i   (awready),
    .wready_i    (wready),
    .last_beat_i (awlen_q[1:0]),
    .data_i      (wr_data_q),
    .awvalid_o   (awvalid),
    .wvalid_o    (wvalid),
    .wdata_o     (wdata),
    .wlast_o     (wlast),
    .aw_done_o   (aw_done),
    .w_done_o    (w_done)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - self-checking bench for cache_axi_bridge
module tb_cache_axi_bridge;

  logic clk = 1'b0;
  logic resetn;
  logic rd_req; logic [2:0] rd_type; logic [31:0] rd_addr;
  logic rd_rdy, ret_valid, ret_last; logic [31:0] ret_data;
  logic wr_req; logic [2:0] wr_type; logic [31:0] wr_addr; logic [3:0] wr_wstrb; logic [127:0] wr_data;
  logic wr_rdy;
  logic [3:0] arid; logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic arvalid, arready;
  logic [3:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0] awid; logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
  logic awvalid, awready;
  logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0] bid; logic [1:0] bresp; logic bvalid, bready;

  int tot = 0;
  int bad = 0;
  bit raw_watch = 1'b0;
  logic [32:0] rq[$];
  logic [36:0] wq[$];

  typedef struct {
    bit           is_wr;
    logic [2:0]   t;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    int           dly;
    bit           tog;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [3:0]   xstrb;
    logic [31:0]  base;
  } vec_t;

  localparam int NV = 7;
  vec_t v[NV];

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [127:0] d, input logic [7:0] len, input logic [3:0] s);
    for (int i = 0; i <= int'(len); i++)
      wq.push_back({(i == int'(len)), s, d[32*i +: 32]});
  endtask

  task automatic rd_accept(input logic [31:0] a, input logic [2:0] t);
    int n;
    n = 0;
    rd_req = 1'b1; rd_addr = a; rd_type = t;
    #1;
    while (!rd_rdy && n < 50) begin cyc(); #1; n++; end
    check("rd_accept_wait", 32'(n < 50), 32'd1);
    cyc();
    rd_req = 1'b0; rd_addr = ~a; rd_type = 3'b001;
  endtask

  task automatic rd_finish(input int ar_delay, input int nbeats, input logic [31:0] base,
                           input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    int arcnt;
    logic [32:0] e;
    arcnt = 0;
    for (int i = 0; i <= ar_delay; i++) begin
      arready = (i == ar_delay);
      #1;
      if (i == 0) begin
        check("araddr", araddr, a);
        check("arlen", 32'(arlen), 32'(len));
        check("arsize", 32'(arsize), 32'(sz));
        check("arburst", 32'(arburst), 32'd1);
        check("arid", 32'(arid), 32'd0);
      end
      if (arvalid) arcnt++;
      cyc();
    end
    arready = 1'b0;
    check("arvalid_cycles", 32'(arcnt), 32'(ar_delay + 1));
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == nbeats - 1);
      rid = 4'hf; rresp = 2'b10;
      rq.push_back({rlast, rdata});
      #1;
      check("rready", 32'(rready), 32'd1);
      if (ret_valid && rq.size() != 0) begin
        e = rq.pop_front();
        check("ret_data", ret_data, e[31:0]);
        check("ret_last", 32'(ret_last), 32'(e[32]));
      end else begin
        check("ret_valid", 32'(ret_valid), 32'd1);
      end
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("ret_valid_idle", 32'(ret_valid), 32'd0);
  endtask

  task automatic wr_accept(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                           input logic [127:0] d, input logic [7:0] len, input logic [3:0] xs);
    int n;
    n = 0;
    wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d;
    #1;
    while (!wr_rdy && n < 50) begin cyc(); #1; n++; end
    check("wr_accept_wait", 32'(n < 50), 32'd1);
    push_w(d, len, xs);
    cyc();
    wr_req = 1'b0; wr_addr = ~a; wr_type = t ^ 3'b100; wr_wstrb = ~s; wr_data = ~d;
  endtask

  task automatic wr_finish(input int aw_at, input bit tog, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz);
    int n;
    bit aw_seen;
    logic [36:0] e;
    n = 0; aw_seen = 1'b0;
    #1;
    check("awvalid_first", 32'(awvalid), 32'd1);
    check("wvalid_first", 32'(wvalid), 32'd1);
    while (!bready && n < 60) begin
      awready = (n >= aw_at);
      wready  = tog ? (n % 2 == 0) : 1'b1;
      #1;
      if (raw_watch) check("raw_hold", 32'(rd_rdy), 32'd0);
      check("wr_rdy_busy", 32'(wr_rdy), 32'd0);
      if (awvalid && awready) begin
        aw_seen = 1'b1;
        check("awaddr", awaddr, a);
        check("awlen", 32'(awlen), 32'(len));
        check("awsize", 32'(awsize), 32'(sz));
        check("awburst", 32'(awburst), 32'd1);
        check("awid", 32'(awid), 32'd1);
      end
      if (wvalid && wready) begin
        if (wq.size() == 0) begin
          check("w_extra_beat", 32'(wvalid), 32'd0);
        end else begin
          e = wq.pop_front();
          check("wdata", wdata, e[31:0]);
          check("wstrb", 32'(wstrb), 32'(e[35:32]));
          check("wlast", 32'(wlast), 32'(e[36]));
        end
      end
      cyc();
      awready = 1'b0; wready = 1'b0;
      #1;
      n++;
    end
    check("b_reached", 32'(bready), 32'd1);
    check("aw_before_b", 32'(aw_seen), 32'd1);
    check("w_beats_left", 32'(wq.size()), 32'd0);
    bvalid = 1'b1; bresp = 2'b10; bid = 4'd1;
    cyc();
    bvalid = 1'b0;
    #1;
    check("wr_rdy_after_b", 32'(wr_rdy), 32'd1);
    check("bready_after_b", 32'(bready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", tot, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{1'b0, 3'b100, 32'h1C00_0120, 4'h0, 128'h0, 0, 1'b0, 8'd3, 3'd2, 4'h0, 32'h0000_00A0};
    v[1] = '{1'b0, 3'b010, 32'h1FD0_0004, 4'h0, 128'h0, 3, 1'b0, 8'd0, 3'd2, 4'h0, 32'h1234_5678};
    v[2] = '{1'b0, 3'b000, 32'h1FD0_0003, 4'h0, 128'h0, 1, 1'b0, 8'd0, 3'd0, 4'h0, 32'h0000_0055};
    v[3] = '{1'b0, 3'b001, 32'h1FD0_0002, 4'h0, 128'h0, 0, 1'b0, 8'd0, 3'd1, 4'h0, 32'h0000_BEEF};
    v[4] = '{1'b1, 3'b100, 32'h0000_1230, 4'h0,
             128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 0, 1'b1, 8'd3, 3'd2, 4'hf, 32'h0};
    v[5] = '{1'b1, 3'b010, 32'h1FD0_0010, 4'b0110,
             128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_1357_9BDF, 2, 1'b0, 8'd0, 3'd2, 4'b0110, 32'h0};
    v[6] = '{1'b1, 3'b000, 32'h1FD0_0021, 4'b0010,
             128'h77777777_66666666_55555555_0000_AB00, 1, 1'b0, 8'd0, 3'd0, 4'b0010, 32'h0};

    resetn = 1'b0;
    rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
    wr_req = 1'b0; wr_type = 3'd0; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
    cyc(); cyc();
    #1;
    check("rst_rd_rdy", 32'(rd_rdy), 32'd1);
    check("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    resetn = 1'b1;
    cyc();

    for (int k = 0; k < NV; k++) begin
      if (!v[k].is_wr) begin
        rd_accept(v[k].addr, v[k].t);
        rd_finish(v[k].dly, int'(v[k].len) + 1, v[k].base, v[k].addr, v[k].len, v[k].size);
        check("rd_rdy_after", 32'(rd_rdy), 32'd1);
      end else begin
        wr_accept(v[k].addr, v[k].t, v[k].strb, v[k].data, v[k].len, v[k].xstrb);
        wr_finish(v[k].dly, v[k].tog, v[k].addr, v[k].len, v[k].size);
      end
    end

    // same-cycle read and write to different lines are both accepted
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_2000;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_3004; wr_wstrb = 4'b1001;
    wr_data = {96'h0, 32'hCAFE_F00D};
    #1;
    check("dual_rd_rdy", 32'(rd_rdy), 32'd1);
    check("dual_wr_rdy", 32'(wr_rdy), 32'd1);
    push_w(wr_data, 8'd0, 4'b1001);
    cyc();
    rd_req = 1'b0; wr_req = 1'b0;
    rd_finish(1, 1, 32'hBEEF_0000, 32'h0000_2000, 8'd0, 3'd2);
    wr_finish(0, 1'b0, 32'h0000_3004, 8'd0, 3'd2);

    // read-after-write to the same line waits for B; other lines pass
    wr_accept(32'h0000_0800, 3'b100, 4'h0, 128'h44444444_33333333_22222222_11111111, 8'd3, 4'hf);
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0808;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("raw_blocked", 32'(rd_rdy), 32'd0);
      cyc();
    end
    rd_addr = 32'h0000_0900;
    #1;
    check("raw_other_line", 32'(rd_rdy), 32'd1);
    rd_accept(32'h0000_0900, 3'b010);
    rd_finish(0, 1, 32'h0900_0000, 32'h0000_0900, 8'd0, 3'd2);
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0808;
    raw_watch = 1'b1;
    wr_finish(0, 1'b0, 32'h0000_0800, 8'd3, 3'd2);
    raw_watch = 1'b0;
    check("raw_released", 32'(rd_rdy), 32'd1);
    rd_accept(32'h0000_0808, 3'b010);
    rd_finish(0, 1, 32'h0808_0000, 32'h0000_0808, 8'd0, 3'd2);

    // reset in the middle of a read burst with a write outstanding
    wr_accept(32'h0000_3000, 3'b100, 4'h0, 128'h1, 8'd3, 4'hf);
    rd_accept(32'h0000_4000, 3'b100);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hE0 + 32'(i); rlast = 1'b0;
      #1;
      check("pre_rst_ret_valid", 32'(ret_valid), 32'd1);
      check("pre_rst_ret_data", ret_data, 32'hE0 + 32'(i));
      cyc();
    end
    rvalid = 1'b1; rdata = 32'hE2;
    resetn = 1'b0;
    #1;
    check("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check("mid_rst_rready", 32'(rready), 32'd0);
    check("mid_rst_awvalid", 32'(awvalid), 32'd0);
    check("mid_rst_wvalid", 32'(wvalid), 32'd0);
    check("mid_rst_bready", 32'(bready), 32'd0);
    check("mid_rst_ret_valid", 32'(ret_valid), 32'd0);
    rq.delete();
    wq.delete();
    rvalid = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    cyc();
    #1;
    check("post_rst_rd_rdy", 32'(rd_rdy), 32'd1);
    check("post_rst_wr_rdy", 32'(wr_rdy), 32'd1);
    check("post_rst_araddr", araddr, 32'd0);
    check("post_rst_awaddr", awaddr, 32'd0);
    check("post_rst_awvalid", 32'(awvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Memory-side responder for the cache's refill/writeback interface (rd_req/rd_rdy/ret_*, wr_req/wr_rdy).
- Converts cache line reads/writes (4 words) and uncached single-word accesses into AXI4 master transactions.
- Sits between one cache instance and the SoC AXI interconnect.
- One read channel and one write channel, each with its own FSM. One outstanding transaction per direction.

Parameters:
- LINE_WORDS, 4, words per cache line. This is the burst length for rd_type/wr_type = 3'b100.
- RD_ID, 4'd0, constant arid.
- WR_ID, 4'd1, constant awid.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous assert, active-low
- rd_req  in  1  cache read request
- rd_type  in  3  000 byte, 001 half, 010 word, 100 line
- rd_addr  in  32  read address
- rd_rdy  out  1  read request accepted when rd_req && rd_rdy
- ret_valid  out  1  return beat valid
- ret_last  out  1  final return beat
- ret_data  out  32  return data
- wr_req  in  1  cache write request
- wr_type  in  3  encoding as rd_type
- wr_addr  in  32  write address
- wr_wstrb  in  4  byte strobe, used for non-line writes only
- wr_data  in  128  line data, word0 = [31:0]; non-line uses [31:0]
- wr_rdy  out  1  write request accepted when wr_req && wr_rdy
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI AR
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI W
- wready  in  1
- bid/bresp/bvalid  in  4/2/1  AXI B
- bready  out  1

Behaviour:
- Reset: all FSMs IDLE; all valid/ready outputs 0 except rd_rdy=1 and wr_rdy=1; address/data registers 0.
- Reset mid-burst abandons the transaction; no recovery attempted.

Read FSM R_IDLE -> R_AR -> R_DATA -> R_IDLE:
- rd_rdy = R_IDLE && !raw_block.
- On accept:
  - latch address → araddr.
  - arlen = (type==100) ? LINE_WORDS-1 : 0.
  - arsize = (type==100) ? 3'b010 : {1'b0, type[1:0]}.
  - arburst = 2'b01 (INCR).
- R_AR: arvalid=1 until arready, then go to R_DATA. Accept-to-arvalid latency is 1 cycle.
- R_DATA:
  - rready=1.
  - ret_valid=rvalid, ret_data=rdata, ret_last=rvalid&&rlast. These are combinational pass-through, zero latency.
  - rvalid&&rlast → R_IDLE.
- rresp and rid are ignored.

Write FSM W_IDLE -> W_DATA -> W_B -> W_IDLE:
- wr_rdy = W_IDLE.
- On accept latch wr_addr, wr_type, wr_wstrb and wr_data (128b).
- awlen as arlen; awsize as arsize; awburst INCR.
- W_DATA:
  - awvalid and wvalid assert together on the cycle after accept.
  - awvalid drops after awready (aw_done flag).
  - 2-bit beat counter selects wdata = data_reg[32*beat +: 32].
  - wstrb = 4'hf for line, latched strobe otherwise.
  - wlast = (beat == awlen[1:0]).
  - Beat advances on wvalid&&wready. wvalid drops after the last beat is accepted (w_done).
  - AW and W may complete in either order or in the same cycle.
- aw_done && w_done → W_B.
- W_B: bready=1; bvalid → W_IDLE, clearing counter and flags. bresp is ignored.

Hazard and arbitration:
- raw_block = (write FSM != W_IDLE) && (rd_addr[31:4] == wr_addr_reg[31:4]). A read never overtakes a pending write to the same line.
- Simultaneous rd_req and wr_req in one cycle: both are accepted when not blocked. A same-cycle same-line pair is not compared.
- Inputs are sampled only at accept. Changes on the cache inputs afterward have no effect.

Decomposition:
- Shared package/header:
  - type codes (TYPE_BYTE/HALF/WORD/LINE)
  - AXI burst/size constants
  - RD_ID/WR_ID
  - FSM state encodings (one-hot, 3 bits each)
- Natural sub-module: axi_wr_beat_ctrl, holding the beat counter, wlast generation, 128→32 data mux and aw_done/w_done flags.
- The read path stays inline.

Test Plan:
- Line read at 0x1C000120: AR araddr=0x1C000120, arlen=3, arsize=2; slave returns 0xA0..0xA3 with rlast on beat 3 → four ret_valid beats, ret_last only on 0xA3, rd_rdy=1 the next cycle.
- Uncached word read at 0x1FD00004, type 010, arready held low 3 cycles → arvalid held 4 cycles, arlen=0; one ret beat with ret_last=1.
- Line write at 0x00001230, wr_data words D0..D3, wready toggling 1,0,1,0… → wdata D0,D1,D2,D3 in order; wstrb=f; wlast only with D3; wr_rdy low until bvalid is seen.
- Uncached write at 0x1FD00010, wstrb 4'b0110, awready arriving 2 cycles after the W beat → single beat wstrb=0110 with wlast=1; FSM reaches W_B only after both handshakes.
- RAW: line write to 0x0800 pending, then rd_req to 0x0808 → rd_rdy=0 until B completes; rd_req to 0x0900 during the same window is accepted immediately.
- resetn low during R_DATA beat 2 → arvalid, rready, awvalid, wvalid, bready and ret_valid go to 0 immediately; rd_rdy=1 and wr_rdy=1 after release.
